// File: rtl/t03_cpu_pkg.sv
// Shared definitions for the team_03 RV32I core control path.
// Holds the base opcode values, the sequencer state and opcode-class
// enumerations, the pc_sel encodings and a helper that maps an opcode
// onto its class.
package t03_cpu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SEL_REL  = 2'd1;  // PC + imm
  localparam logic [1:0] PC_SEL_JALR = 2'd2;  // rs1 + imm

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  // CLS_ILLEGAL is the all-zero value so a cleared class register reads as
  // "nothing valid latched".
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_OP,
    CLS_SYSTEM
  } opclass_t;

  function automatic opclass_t classify(input logic [6:0] opc);
    opclass_t c;
    case (opc)
      OPC_OP_IMM: c = CLS_OP_IMM;
      OPC_LOAD:   c = CLS_LOAD;
      OPC_STORE:  c = CLS_STORE;
      OPC_BRANCH: c = CLS_BRANCH;
      OPC_JAL:    c = CLS_JAL;
      OPC_JALR:   c = CLS_JALR;
      OPC_LUI:    c = CLS_LUI;
      OPC_AUIPC:  c = CLS_AUIPC;
      OPC_OP:     c = CLS_OP;
      OPC_SYSTEM: c = CLS_SYSTEM;
      default:    c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/t03_op_classifier.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in  7  instruction[6:0]
//   cls     out    opcode class
//   rf_we   out 1  class writes the register file in WB
//   pc_sel  out 2  PC source used when the class redirects the PC
//                  (BRANCH reports PC_SEL_REL; the taken condition is
//                  applied by the sequencer)
module t03_op_classifier
  import t03_cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls,
  output logic       rf_we,
  output logic [1:0] pc_sel
);

  always_comb begin
    cls    = classify(opcode);
    rf_we  = 1'b0;
    pc_sel = PC_SEL_SEQ;
    case (cls)
      CLS_OP_IMM, CLS_OP, CLS_LOAD, CLS_LUI, CLS_AUIPC: rf_we = 1'b1;
      CLS_JAL: begin
        rf_we  = 1'b1;
        pc_sel = PC_SEL_REL;
      end
      CLS_JALR: begin
        rf_we  = 1'b1;
        pc_sel = PC_SEL_JALR;
      end
      CLS_BRANCH: pc_sel = PC_SEL_REL;
      default: ;
    endcase
  end

endmodule

// File: rtl/t03_cpu_sequencer.sv
// Multi-cycle control FSM for the team_03 RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and
// handshakes fetch / load / store requests with the memory arbiter.
// Optional ack timeout: define T03_SEQ_TIMEOUT_EN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instruction, i_ack  fetched word and fetch completion
//   d_ack               load/store completion
//   branch_taken        ALU compare result, sampled in EXEC
//   i_req, d_read, d_write  arbiter requests, held until acked
//   ir_en               IR latch strobe (with i_ack in FETCH)
//   imm_valid           IR stable during DECODE/EXEC/MEM
//   pc_en, pc_sel       PC update strobe and source in WB
//   rf_we               register-file write strobe in WB
//   illegal, halted, fault  status flags
module t03_cpu_sequencer
  import t03_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        i_ack,
  input  logic        d_ack,
  input  logic        branch_taken,
  output logic        i_req,
  output logic        d_read,
  output logic        d_write,
  output logic        ir_en,
  output logic        imm_valid,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        illegal,
  output logic        halted,
  output logic        fault
);

  if ((64'd1 << TMO_W) < 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
    $error("TMO_W too narrow to count TIMEOUT_CYCLES");
  end

  state_t     state;
  opclass_t   cls_q;
  logic       rf_we_attr_q;
  logic [1:0] pc_sel_attr_q;
  logic       taken_q;
  logic       illegal_q;

  opclass_t   fetch_cls;
  logic       fetch_rf_we;
  logic [1:0] fetch_pc_sel;

  // Only the opcode field steers the sequencer; the rest is for the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:7];

  t03_op_classifier u_classifier (
    .opcode (instruction[6:0]),
    .cls    (fetch_cls),
    .rf_we  (fetch_rf_we),
    .pc_sel (fetch_pc_sel)
  );

`ifdef T03_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] wait_cnt;
  logic             fault_q;
  logic             tmo_hit;
  assign tmo_hit = (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      cls_q         <= CLS_ILLEGAL;
      rf_we_attr_q  <= 1'b0;
      pc_sel_attr_q <= PC_SEL_SEQ;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef T03_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (i_ack) begin
            cls_q         <= fetch_cls;
            rf_we_attr_q  <= fetch_rf_we;
            pc_sel_attr_q <= fetch_pc_sel;
            state         <= S_DECODE;
          end
`ifdef T03_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DECODE: begin
          if (cls_q == CLS_SYSTEM) begin
            state <= S_HALT;
          end else if (cls_q == CLS_ILLEGAL) begin
            // Skip execution: WB with rf_we=0 just advances PC by 4.
            illegal_q <= 1'b1;
            state     <= S_WB;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          taken_q <= branch_taken;
          if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
            state <= S_MEM;
`ifdef T03_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (d_ack) begin
            state <= S_WB;
          end
`ifdef T03_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          state <= S_FETCH;
`ifdef T03_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    i_req     = (state == S_FETCH);
    ir_en     = (state == S_FETCH) && i_ack && !rst;
    imm_valid = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM);
    d_read    = (state == S_MEM) && (cls_q == CLS_LOAD);
    d_write   = (state == S_MEM) && (cls_q == CLS_STORE);
    pc_en     = (state == S_WB);
    rf_we     = (state == S_WB) && rf_we_attr_q;
    pc_sel    = PC_SEL_SEQ;
    if (state == S_WB) begin
      if (cls_q == CLS_BRANCH) begin
        pc_sel = taken_q ? PC_SEL_REL : PC_SEL_SEQ;
      end else begin
        pc_sel = pc_sel_attr_q;
      end
    end
    illegal = illegal_q;
    halted  = (state == S_HALT);
`ifdef T03_SEQ_TIMEOUT_EN
    fault   = fault_q;
`else
    fault   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_t03_cpu_sequencer.sv
module tb_t03_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        i_ack, d_ack, branch_taken;
  logic        i_req, d_read, d_write, ir_en, imm_valid, pc_en, rf_we;
  logic [1:0]  pc_sel;
  logic        illegal, halted, fault;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rf_we;
    logic [1:0] pc_sel;
    int         cycles;
  } wb_exp_t;

  wb_exp_t sb[$];
  logic    ill_seen = 1'b0;

  logic [8:0] ctl;
  assign ctl = {i_req, ir_en, imm_valid, d_read, d_write, pc_en, rf_we, pc_sel};

  always #5 clk = ~clk;

  t03_cpu_sequencer #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .i_ack        (i_ack),
    .d_ack        (d_ack),
    .branch_taken (branch_taken),
    .i_req        (i_req),
    .d_read       (d_read),
    .d_write      (d_write),
    .ir_en        (ir_en),
    .imm_valid    (imm_valid),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .illegal      (illegal),
    .halted       (halted),
    .fault        (fault)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_ack = 1'b0; d_ack = 1'b0; branch_taken = 1'b0;
    instruction = 32'h0;
    step();
    ill_seen = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ctl, illegal, halted, fault} !== {9'b1_0000_0000, 3'b000})
      $display("FAIL reset_outputs: got ctl=%b flags=%b%b%b want ctl=100000000 flags=000",
               ctl, illegal, halted, fault);
    else n_pass++;
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from the current FETCH cycle. iwait/dwait are the
  // ack delays; stray drives acks in states where they must be ignored.
  task automatic test_instr(input string name, input logic [31:0] ins,
                            input int iwait, input int dwait,
                            input logic taken, input logic stray);
    logic [6:0] opc;
    logic e_we, e_ld, e_st, e_sys, e_ill;
    logic [1:0] e_sel;
    wb_exp_t e, got;
    int cyc;
    opc = ins[6:0];
    e_we = 1'b0; e_ld = 1'b0; e_st = 1'b0; e_sys = 1'b0; e_ill = 1'b0;
    e_sel = 2'd0;
    case (opc)
      7'h13, 7'h33, 7'h37, 7'h17: e_we = 1'b1;
      7'h03: begin e_we = 1'b1; e_ld = 1'b1; end
      7'h23: e_st = 1'b1;
      7'h63: e_sel = taken ? 2'd1 : 2'd0;
      7'h6F: begin e_we = 1'b1; e_sel = 2'd1; end
      7'h67: begin e_we = 1'b1; e_sel = 2'd2; end
      7'h73: e_sys = 1'b1;
      default: e_ill = 1'b1;
    endcase
    if (!e_sys) begin
      e.rf_we  = e_we;
      e.pc_sel = e_sel;
      e.cycles = (iwait + 1) + 1 + (e_ill ? 0 : 1) + ((e_ld || e_st) ? dwait + 1 : 0) + 1;
      sb.push_back(e);
    end
    cyc = 0;

    for (int k = 0; k <= iwait; k++) begin
      i_ack = (k == iwait);
      d_ack = stray;
      instruction = (k == iwait) ? ins : $urandom;
      @(negedge clk);
      n_total++;
      if (ctl !== {1'b1, (k == iwait), 7'b0})
        $display("FAIL %s fetch%0d: got ctl=%b want %b", name, k, ctl, {1'b1, (k == iwait), 7'b0});
      else n_pass++;
      step(); cyc++;
    end
    i_ack = stray; d_ack = stray; instruction = $urandom;

    @(negedge clk);
    n_total++;
    if (ctl !== 9'b001_0000_00)
      $display("FAIL %s decode: got ctl=%b want 001000000", name, ctl);
    else n_pass++;
    step(); cyc++;

    if (e_sys) begin
      for (int k = 0; k < 3; k++) begin
        i_ack = 1'b1; d_ack = 1'b1;
        @(negedge clk);
        n_total++;
        if ({halted, ctl} !== 10'b1_000000000)
          $display("FAIL %s halt%0d: got halted=%b ctl=%b want halted=1 ctl=000000000",
                   name, k, halted, ctl);
        else n_pass++;
        step();
      end
      i_ack = 1'b0; d_ack = 1'b0;
      return;
    end

    if (e_ill) ill_seen = 1'b1;
    else begin
      branch_taken = taken;
      @(negedge clk);
      n_total++;
      if (ctl !== 9'b001_0000_00)
        $display("FAIL %s exec: got ctl=%b want 001000000", name, ctl);
      else n_pass++;
      step(); cyc++;
      branch_taken = ~taken;
    end

    if (e_ld || e_st) begin
      for (int k = 0; k <= dwait; k++) begin
        d_ack = (k == dwait);
        i_ack = stray;
        @(negedge clk);
        n_total++;
        if (ctl !== {2'b00, 1'b1, e_ld, e_st, 4'b0})
          $display("FAIL %s mem%0d: got ctl=%b want %b", name, k, ctl, {2'b00, 1'b1, e_ld, e_st, 4'b0});
        else n_pass++;
        step(); cyc++;
      end
      d_ack = stray; i_ack = stray;
    end

    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: got empty queue want 1 entry", name);
    end else begin
      got = sb.pop_front();
      n_total++;
      if (ctl !== {5'b0, 1'b1, got.rf_we, got.pc_sel})
        $display("FAIL %s wb: got ctl=%b want %b", name, ctl, {5'b0, 1'b1, got.rf_we, got.pc_sel});
      else n_pass++;
      n_total++;
      if (cyc + 1 != got.cycles)
        $display("FAIL %s latency: got %0d want %0d", name, cyc + 1, got.cycles);
      else n_pass++;
    end
    n_total++;
    if ({illegal, halted, fault} !== {ill_seen, 2'b00})
      $display("FAIL %s flags: got %b%b%b want %b00", name, illegal, halted, fault, ill_seen);
    else n_pass++;
    step();
    i_ack = 1'b0; d_ack = 1'b0;
  endtask

  task automatic test_alu();
    test_instr("addi", 32'h00500093, 1, 0, 1'b0, 1'b0);
    test_instr("lui",  32'h123450B7, 0, 0, 1'b1, 1'b1);
    test_instr("add",  32'h002081B3, 2, 0, 1'b0, 1'b1);
    test_instr("auipc", 32'h00001217, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_load_store();
    test_instr("lw", 32'h0040A103, 0, 3, 1'b0, 1'b0);
    test_instr("sw", 32'h0020A223, 0, 2, 1'b0, 1'b1);
    test_instr("lw_nowait", 32'h0040A103, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_branch();
    test_instr("beq_taken",    32'h00208463, 0, 0, 1'b1, 1'b0);
    test_instr("beq_nottaken", 32'h00208463, 0, 0, 1'b0, 1'b1);
    test_instr("jal",          32'h008000EF, 0, 0, 1'b0, 1'b0);
    test_instr("jalr",         32'h000080E7, 1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_illegal();
    test_instr("illegal", 32'h0000007F, 0, 0, 1'b0, 1'b1);
    test_instr("addi_after_ill", 32'h00500093, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    test_instr("ecall", 32'h00000073, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    n_total++;
    if (illegal !== 1'b0)
      $display("FAIL rst_clears_illegal: got %b want 0", illegal);
    else n_pass++;
    i_ack = 1'b1; instruction = 32'h0040A103;
    step();
    i_ack = 1'b0;
    step();
    step();
    @(negedge clk);
    n_total++;
    if (d_read !== 1'b1)
      $display("FAIL midmem_dread: got %b want 1", d_read);
    else n_pass++;
    rst = 1'b1;
    step();
    @(negedge clk);
    n_total++;
    if (ctl !== 9'b1_0000_0000)
      $display("FAIL midmem_rst: got ctl=%b want 100000000", ctl);
    else n_pass++;
    step();
    rst = 1'b0; d_ack = 1'b1;
    @(negedge clk);
    n_total++;
    if (ctl !== 9'b1_0000_0000)
      $display("FAIL late_dack: got ctl=%b want 100000000", ctl);
    else n_pass++;
    step();
    d_ack = 1'b0;
    test_instr("addi_after_rst", 32'h00500093, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic e_fault, e_ireq;
    test_reset();
    i_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
`ifdef T03_SEQ_TIMEOUT_EN
      e_fault = (k >= 4);
`else
      e_fault = 1'b0;
`endif
      e_ireq = !e_fault;
      @(negedge clk);
      n_total++;
      if ({fault, i_req} !== {e_fault, e_ireq})
        $display("FAIL timeout%0d: got fault=%b i_req=%b want fault=%b i_req=%b",
                 k, fault, i_req, e_fault, e_ireq);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_illegal();
    test_halt();
    test_reset_mid_mem();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
